// File: rtl/gray_pack_pkg.sv
// Shared types and constants for the gray-stream word packer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents: FSM state enum, pack geometry, FIFO entry layout {sof, eol, data}.
package gray_pack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int PIX_PER_WORD = 4;
  localparam int WORD_W       = 32;
  localparam int ENTRY_W      = WORD_W + 2;

  // One buffered word with its frame/line tags.
  typedef struct packed {
    logic              sof;
    logic              eol;
    logic [WORD_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/gray_pack_wr_if.sv
// Valid/ready word bus from the packer toward the frame-buffer write path.
// Latency: n/a (wires only).
// Backpressure: a word moves when m_valid and m_ready are both high.
//
// Ports: m_data (32b, pixel 0 in [7:0]), m_sof, m_eol, m_valid from master;
//        m_ready from slave.
interface gray_pack_wr_if;
  import gray_pack_pkg::*;

  logic [WORD_W-1:0] m_data;
  logic              m_sof;
  logic              m_eol;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, m_sof, m_eol, m_valid, input m_ready);
  modport slave  (input m_data, m_sof, m_eol, m_valid, output m_ready);

endinterface

// File: rtl/gray_pack_fifo.sv
// Synchronous FIFO with registered first-word-fall-through output.
// Latency: a word written at edge N is presented on rd_vld/rd_dat after edge N+1.
// Backpressure: writes rejected when full unless a pop happens in the same cycle.
//
// Ports: clk, rst (sync, active-high), wr_vld/wr_dat in, rd_vld/rd_dat out,
//        rd_rdy in, full/empty status. Capacity is exactly DEPTH words.
module gray_pack_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  input  logic         rd_rdy,
  output logic         full,
  output logic         empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW:0]   count;
  logic [AW:0]   count_left;
  logic          pop;
  logic          push_ok;

  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign pop        = rd_vld & rd_rdy;
  assign push_ok    = wr_vld & (~full | pop);
  assign rd_ptr_nxt = rd_ptr + AW'(pop);
  // Entries still stored after this cycle's pop, ignoring this cycle's push.
  // The output register only looks at these, which keeps a fresh write one
  // cycle away from rd_vld and keeps the head stable while stalled.
  assign count_left = count - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rd_vld <= 1'b0;
      rd_dat <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count_left + (AW+1)'(push_ok);
      rd_vld <= (count_left != '0);
      rd_dat <= mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/gray_pack_wr.sv
// Packs 4 gray pixels per 32-bit word, tags sof/eol, buffers words for the write path.
// Latency: FIFO write 1 cycle after the 4th pixel; m_valid no earlier than 2 cycles after it.
// Backpressure: input is never stalled; a word arriving at a full FIFO is dropped (ovf_err).
//
// Ports: clk, rst (sync, active-high); per_img_vsync/href/gray input stream;
//        m (gray_pack_wr_if.master) word output; frame_done pulse, ovf_err sticky,
//        line_err/frame_err pulses.
// Optional: GRAY_PACK_FRAME_CHECK_EN compiles in line-length and line-count checks;
//           without it line_err and frame_err are tied low.
module gray_pack_wr
  import gray_pack_pkg::*;
#(
  parameter logic [10:0] IMG_HDISP  = 11'd640,
  parameter logic [10:0] IMG_VDISP  = 11'd480,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  per_img_vsync,
  input  logic                  per_img_href,
  input  logic [7:0]            per_img_gray,
  gray_pack_wr_if.master        m,
  output logic                  frame_done,
  output logic                  ovf_err,
  output logic                  line_err,
  output logic                  frame_err
);

  state_t            state;
  logic              vsync_d;
  logic              href_d;
  logic              sof_pend;
  logic              drain_arm;
  logic              pack_vld;
  logic [1:0]        lane;
  logic [WORD_W-1:0] pack_data;

  logic   vsync_rise;
  logic   vsync_fall;
  logic   href_fall;
  logic   pix_en;
  logic   partial;
  logic   push;
  logic   drop;
  logic   frame_end;
  logic   fifo_full;
  logic   fifo_empty;
  entry_t wr_entry;
  entry_t rd_entry;

  assign vsync_rise = per_img_vsync & ~vsync_d;
  assign vsync_fall = ~per_img_vsync & vsync_d;
  assign href_fall  = href_d & ~per_img_href;
  assign pix_en     = per_img_vsync & per_img_href & (state == FRAME);
  // A line that ends mid-word flushes what it has; unused lanes are already zero.
  assign partial    = href_fall & (lane != 2'd0);
  // A full word (pack_vld) and a partial flush never coincide: pack_vld implies lane==0.
  assign push       = pack_vld | partial;
  assign drop       = push & fifo_full & ~(m.m_valid & m.m_ready);

  assign wr_entry.sof  = sof_pend;
  assign wr_entry.eol  = href_fall;
  assign wr_entry.data = pack_data;

  // drain_arm holds the exit off for one cycle after the vsync fall.
  assign frame_end = (state == DRAIN) &
                     (vsync_rise | (drain_arm & fifo_empty & ~push));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      // Seeded high so a vsync already high when reset lifts is not taken as a frame start.
      vsync_d    <= 1'b1;
      href_d     <= 1'b0;
      sof_pend   <= 1'b0;
      drain_arm  <= 1'b0;
      pack_vld   <= 1'b0;
      lane       <= 2'd0;
      pack_data  <= '0;
      frame_done <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      vsync_d    <= per_img_vsync;
      href_d     <= per_img_href;
      frame_done <= frame_end;
      pack_vld   <= pix_en && (lane == 2'd3);
      if (drop) begin
        ovf_err <= 1'b1;
      end
      if (push) begin
        sof_pend <= 1'b0;
      end
      if (pix_en) begin
        // Lane 0 rewrites the whole word so a later partial flush carries zeros.
        if (lane == 2'd0) begin
          pack_data <= {24'd0, per_img_gray};
        end else begin
          pack_data[{lane, 3'b000} +: 8] <= per_img_gray;
        end
        lane <= lane + 2'd1;
      end else if (partial) begin
        lane <= 2'd0;
      end
      unique case (state)
        IDLE: begin
          if (vsync_rise) begin
            state    <= FRAME;
            lane     <= 2'd0;
            sof_pend <= 1'b1;
          end
        end
        FRAME: begin
          if (vsync_fall) begin
            state     <= DRAIN;
            drain_arm <= 1'b0;
          end
        end
        DRAIN: begin
          drain_arm <= 1'b1;
          if (vsync_rise) begin
            // Back-to-back frame: close the old one now, keep its words queued.
            state    <= FRAME;
            lane     <= 2'd0;
            sof_pend <= 1'b1;
          end else if (frame_end) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GRAY_PACK_FRAME_CHECK_EN
  logic [10:0] pix_cnt;
  logic [10:0] line_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt   <= 11'd0;
      line_cnt  <= 11'd0;
      line_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      line_err  <= 1'b0;
      frame_err <= 1'b0;
      if (pix_en && (pix_cnt != 11'h7FF)) begin
        pix_cnt <= pix_cnt + 11'd1;
      end
      // Only lines that carried pixels count.
      if (href_fall && (pix_cnt != 11'd0)) begin
        line_err <= (pix_cnt != IMG_HDISP);
        pix_cnt  <= 11'd0;
        if (line_cnt != 11'h7FF) begin
          line_cnt <= line_cnt + 11'd1;
        end
      end
      if (frame_end) begin
        frame_err <= (line_cnt != IMG_VDISP);
      end
      if (vsync_rise && (state != FRAME)) begin
        pix_cnt  <= 11'd0;
        line_cnt <= 11'd0;
      end
    end
  end
`else
  logic [21:0] unused_geom;
  assign unused_geom = {IMG_HDISP, IMG_VDISP};
  assign line_err    = 1'b0;
  assign frame_err   = 1'b0;
`endif

  gray_pack_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (push),
    .wr_dat (wr_entry),
    .rd_vld (m.m_valid),
    .rd_dat (rd_entry),
    .rd_rdy (m.m_ready),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign m.m_data = rd_entry.data;
  assign m.m_sof  = rd_entry.sof;
  assign m.m_eol  = rd_entry.eol;

endmodule

// File: tb/tb_gray_pack_wr.sv
// Self-checking bench for gray_pack_wr: directed frames, overflow, reset, random ready.
module tb_gray_pack_wr;

  localparam logic [10:0] HD    = 11'd8;
  localparam logic [10:0] VD    = 11'd2;
  localparam int          DEPTH = 16;
`ifdef GRAY_PACK_FRAME_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       vsync = 1'b0;
  logic       href  = 1'b0;
  logic [7:0] gray  = 8'd0;
  logic       frame_done, ovf_err, line_err, frame_err;

  gray_pack_wr_if bus();

  gray_pack_wr #(
    .IMG_HDISP  (HD),
    .IMG_VDISP  (VD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .per_img_vsync (vsync),
    .per_img_href  (href),
    .per_img_gray  (gray),
    .m             (bus),
    .frame_done    (frame_done),
    .ovf_err       (ovf_err),
    .line_err      (line_err),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        sof;
    logic        eol;
  } word_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  word_t got_q[$];
  word_t exp_t[8];
  word_t hold_w;
  logic  hold_pend = 1'b0;
  logic  rand_rdy  = 1'b0;
  logic [7:0] pix_val;
  int fd_cnt, le_cnt, fe_cnt, fe_fd_cnt, fd_cyc, last_hs, first_v, p4_cyc, vfall_cyc;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (hold_pend && bus.m_valid) begin
      chk("hold_data", bus.m_data, hold_w.data);
      chk("hold_tags", {bus.m_sof, bus.m_eol}, {hold_w.sof, hold_w.eol});
    end
    hold_pend = bus.m_valid && !bus.m_ready;
    hold_w    = '{bus.m_data, bus.m_sof, bus.m_eol};
    if (bus.m_valid && bus.m_ready) begin
      got_q.push_back('{bus.m_data, bus.m_sof, bus.m_eol});
      last_hs = cyc;
    end
    if (bus.m_valid && first_v < 0) first_v = cyc;
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (line_err) le_cnt++;
    if (frame_err) begin
      fe_cnt++;
      if (frame_done) fe_fd_cnt++;
    end
  end

  task automatic clear_mon();
    got_q.delete();
    fd_cnt = 0; le_cnt = 0; fe_cnt = 0; fe_fd_cnt = 0;
    fd_cyc = 0; last_hs = 0; first_v = -1; p4_cyc = -1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.m_ready = ($urandom_range(0, 99) < 30);
    end
  endtask

  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) begin
      href = 1'b1;
      gray = pix_val;
      if (i == 3 && p4_cyc < 0) p4_cyc = cyc;
      pix_val = pix_val + 8'd1;
      tick(1);
    end
    href = 1'b0;
    gray = 8'd0;
    tick(4);
  endtask

  task automatic send_frame(input int nl, input int len0, input int len,
                            input logic [7:0] base, input logic [7:0] step);
    pix_val = base;
    vsync   = 1'b1;
    tick(3);
    for (int l = 0; l < nl; l++) begin
      if (step != 8'd0) pix_val = base + 8'(step * l);
      send_line(l == 0 ? len0 : len);
    end
    vsync     = 1'b0;
    vfall_cyc = cyc;
    tick(1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (fd_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    if (fd_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: got %0d pulses, expected %0d", fd_cnt, target);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_m_valid"}, bus.m_valid, 1'b0);
    chk({tag, "_m_data"}, bus.m_data, 32'd0);
    chk({tag, "_m_sof"}, bus.m_sof, 1'b0);
    chk({tag, "_m_eol"}, bus.m_eol, 1'b0);
    chk({tag, "_frame_done"}, frame_done, 1'b0);
    chk({tag, "_ovf_err"}, ovf_err, 1'b0);
    chk({tag, "_line_err"}, line_err, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] w;
    bus.m_ready = 1'b1;
    exp_t[0] = '{32'h03020100, 1'b1, 1'b0};
    exp_t[1] = '{32'h07060504, 1'b0, 1'b1};
    exp_t[2] = '{32'h0B0A0908, 1'b0, 1'b0};
    exp_t[3] = '{32'h0F0E0D0C, 1'b0, 1'b1};
    exp_t[4] = '{32'h13121110, 1'b1, 1'b0};
    exp_t[5] = '{32'h00001514, 1'b0, 1'b1};
    exp_t[6] = '{32'h23222120, 1'b0, 1'b0};
    exp_t[7] = '{32'h27262524, 1'b0, 1'b1};
    clear_mon();
    tick(3);
    chk_outputs_zero("reset");
    rst = 1'b0;
    tick(2);

    // 8x2 frame, pixels 0x00..0x0F.
    clear_mon();
    send_frame(2, 8, 8, 8'h00, 8'h00);
    wait_done(1, 100);
    tick(5);
    chk("t1_words", got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        chk($sformatf("t1_data%0d", i), got_q[i].data, exp_t[i].data);
        chk($sformatf("t1_tags%0d", i), {got_q[i].sof, got_q[i].eol}, {exp_t[i].sof, exp_t[i].eol});
      end
    end
    chk("t1_valid_latency", first_v - p4_cyc, 3);
    chk("t1_done_after_vfall", (fd_cyc - vfall_cyc) >= 3, 1'b1);
    chk("t1_frame_done_cnt", fd_cnt, 1);
    chk("t1_line_err_cnt", le_cnt, 0);
    chk("t1_frame_err_cnt", fe_cnt, 0);

    // 6-pixel line then 8-pixel line.
    clear_mon();
    send_frame(2, 6, 8, 8'h10, 8'h10);
    wait_done(1, 100);
    tick(5);
    chk("t2_words", got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        chk($sformatf("t2_data%0d", i), got_q[i].data, exp_t[i+4].data);
        chk($sformatf("t2_tags%0d", i), {got_q[i].sof, got_q[i].eol}, {exp_t[i+4].sof, exp_t[i+4].eol});
      end
    end
    chk("t2_line_err_cnt", le_cnt, CHK);
    chk("t2_frame_err_cnt", fe_cnt, 0);
    chk("t2_frame_done_cnt", fd_cnt, 1);

    // Overflow: 80-pixel line (20 words) into a 16-deep FIFO with the sink stalled.
    clear_mon();
    bus.m_ready = 1'b0;
    send_frame(1, 80, 80, 8'h40, 8'h00);
    tick(5);
    chk("t3_ovf_err", ovf_err, 1'b1);
    chk("t3_valid_stalled", bus.m_valid, 1'b1);
    chk("t3_head_data", bus.m_data, 32'h43424140);
    chk("t3_no_done_while_full", fd_cnt, 0);
    bus.m_ready = 1'b1;
    wait_done(1, 200);
    tick(3);
    chk("t3_words", got_q.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'h40 + 8'(4 * i);
      w = {b + 8'd3, b + 8'd2, b + 8'd1, b};
      if (i < got_q.size()) begin
        chk($sformatf("t3_data%0d", i), got_q[i].data, w);
        chk($sformatf("t3_tags%0d", i), {got_q[i].sof, got_q[i].eol}, {i == 0, 1'b0});
      end
    end
    chk("t3_ovf_sticky", ovf_err, 1'b1);
    chk("t3_line_err_cnt", le_cnt, CHK);
    chk("t3_frame_err_cnt", fe_cnt, CHK);
    chk("t3_frame_err_with_done", fe_fd_cnt, fe_cnt);

    // Reset in the middle of a line.
    clear_mon();
    pix_val = 8'h30;
    vsync = 1'b1;
    tick(3);
    for (int i = 0; i < 6; i++) begin
      href = 1'b1;
      gray = pix_val;
      pix_val = pix_val + 8'd1;
      tick(1);
    end
    chk("t4_ovf_before_rst", ovf_err, 1'b1);
    rst = 1'b1;
    tick(1);
    chk_outputs_zero("t4_rst");
    tick(2);
    rst = 1'b0;
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      gray = pix_val;
      pix_val = pix_val + 8'd1;
      tick(1);
    end
    href = 1'b0;
    tick(4);
    vsync = 1'b0;
    tick(10);
    chk("t4_discarded_words", got_q.size(), 0);
    chk("t4_discarded_done", fd_cnt, 0);
    send_frame(2, 8, 8, 8'h50, 8'h00);
    wait_done(1, 100);
    tick(3);
    chk("t4_words", got_q.size(), 4);
    if (got_q.size() >= 4) begin
      chk("t4_first_data", got_q[0].data, 32'h53525150);
      chk("t4_first_sof", got_q[0].sof, 1'b1);
      chk("t4_last_data", got_q[3].data, 32'h5F5E5D5C);
      chk("t4_last_eol", got_q[3].eol, 1'b1);
    end
    chk("t4_ovf_cleared", ovf_err, 1'b0);

    // 8x8 frame with m_ready high 30% of cycles.
    clear_mon();
    rand_rdy = 1'b1;
    send_frame(8, 8, 8, 8'h00, 8'h00);
    wait_done(1, 600);
    rand_rdy = 1'b0;
    bus.m_ready = 1'b1;
    tick(3);
    chk("t5_words", got_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      b = 8'(4 * i);
      w = {b + 8'd3, b + 8'd2, b + 8'd1, b};
      if (i < got_q.size()) begin
        chk($sformatf("t5_data%0d", i), got_q[i].data, w);
        chk($sformatf("t5_tags%0d", i), {got_q[i].sof, got_q[i].eol}, {i == 0, (i % 2) == 1});
      end
    end
    chk("t5_done_after_last_hs", fd_cyc > last_hs, 1'b1);
    chk("t5_frame_done_cnt", fd_cnt, 1);
    chk("t5_ovf_err", ovf_err, 1'b0);
    chk("t5_line_err_cnt", le_cnt, 0);
    chk("t5_frame_err_cnt", fe_cnt, CHK);
    chk("t5_frame_err_with_done", fe_fd_cnt, fe_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
